// File: rtl/ifu.sv
// Multi-cycle instruction fetch unit: one outstanding fetch, delivered to decode, then waits for next PC.
// Optional IFU_MISALIGN_CHECK_EN turns a misaligned PC into a local fault instead of a memory request.
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h80000000,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  output logic        imem_rsp_ready,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault,
  input  logic        npc_valid,
  output logic        npc_ready,
  input  logic [31:0] npc
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2,
    S_NPC  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        inst_fault_q, inst_fault_d;
  logic        misalign;

`ifdef IFU_MISALIGN_CHECK_EN
  always_comb misalign = (pc_q[1:0] != 2'b00);
`else
  always_comb misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      inst_q       <= NOP_INST;
      inst_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_fault_q <= inst_fault_d;
    end
  end

  // Handshake inputs are only looked at in the state that owns them.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_fault_d = inst_fault_q;
    unique case (state_q)
      S_REQ: begin
        if (misalign) begin
          state_d      = S_OUT;
          inst_d       = NOP_INST;
          inst_fault_d = 1'b1;
        end else if (imem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          state_d      = S_OUT;
          inst_d       = imem_rsp_err ? NOP_INST : imem_rsp_data;
          inst_fault_d = imem_rsp_err;
        end
      end
      S_OUT: begin
        if (inst_ready) state_d = S_NPC;
      end
      S_NPC: begin
        if (npc_valid) begin
          state_d = S_REQ;
          pc_d    = npc;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    imem_req_valid = (state_q == S_REQ) && !misalign;
    imem_req_addr  = {pc_q[31:2], 2'b00};
    imem_rsp_ready = (state_q == S_WAIT);
    inst_valid     = (state_q == S_OUT);
    npc_ready      = (state_q == S_NPC);
    inst           = inst_q;
    inst_pc        = pc_q;
    inst_fault     = inst_fault_q;
  end

endmodule

// File: doc/ifu.md
# ifu

Multi-cycle instruction fetch unit feeding the decode stage of the NPC core. It holds the architectural PC and issues one word-read request per instruction over a valid/ready instruction-memory port. It delivers the returned instruction and its PC to decode over a valid/ready handshake, then waits for the next PC from the write-back side before fetching again. Only one instruction is in flight at a time; there is no prediction.

## Interface
Parameters:
- `RESET_PC`, 32'h80000000, PC loaded on reset.
- `NOP_INST`, 32'h00000013, instruction word substituted on a fetch fault.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: memory accepts request.
- `imem_req_addr` out 32: word address of the fetch; bits [1:0] are always 0.
- `imem_rsp_valid` in 1: response valid.
- `imem_rsp_ready` out 1: IFU accepts response.
- `imem_rsp_data` in 32: fetched instruction.
- `imem_rsp_err` in 1: access error, qualified by `imem_rsp_valid`.
- `inst_valid` out 1: instruction available to decode.
- `inst_ready` in 1: decode accepts instruction.
- `inst` out 32: instruction word.
- `inst_pc` out 32: PC of `inst`.
- `inst_fault` out 1: `inst` is a fault substitute.
- `npc_valid` in 1: next PC valid.
- `npc_ready` out 1: IFU accepts next PC.
- `npc` in 32: next PC.

## Operation
- State machine with states REQ, WAIT, OUT and NPC.
- REQ:
  - `imem_req_valid`=1 and `imem_req_addr`={pc[31:2],2'b00}.
  - On `imem_req_valid && imem_req_ready`, go to WAIT.
- WAIT:
  - `imem_rsp_ready`=1.
  - On `imem_rsp_valid`, capture data into the `inst` register, set `inst_fault`=`imem_rsp_err`, and go to OUT.
  - If `imem_rsp_err`=1, load `NOP_INST` instead of `imem_rsp_data`.
- OUT:
  - `inst_valid`=1.
  - On `inst_ready`, go to NPC.
- NPC:
  - `npc_ready`=1.
  - On `npc_valid`, set pc<=`npc` and go to REQ.
- All handshake outputs are decoded from the state. Each is high only in the state named above.
- `inst_pc` always equals the pc register. pc changes only on the NPC handshake.
- `inst` and `inst_fault` are registers. They change only on response capture or reset.
- Reset is synchronous:
  - state goes to REQ and pc to `RESET_PC`.
  - `inst` goes to `NOP_INST` and `inst_fault` to 0.
  - The effect is visible in the cycle after the edge on which `rst` is sampled high.
- Reset mid-operation aborts any transaction. The instruction memory shares `rst`, so no stale response can follow reset, and the IFU does not filter one.
- Handshake inputs are ignored outside their state. For example, `npc_valid` in OUT has no effect.

## Timing
- Values while `rst`=1, and the first cycle after reset deasserts:
  - `imem_req_valid`=1, `imem_req_addr`=`RESET_PC`.
  - `imem_rsp_ready`=0, `inst_valid`=0, `npc_ready`=0.
  - `inst`=`NOP_INST`, `inst_pc`=`RESET_PC`, `inst_fault`=0.
- `imem_req_valid` and `imem_req_addr` stay stable until accepted. `inst_valid`, `inst`, `inst_pc` and `inst_fault` stay stable until accepted.
- A response is never accepted in the request-accept cycle, because `imem_rsp_ready`=0 in REQ.
- Minimum latencies:
  - Request accepted at cycle T, response at T+1, then `inst_valid`=1 at T+2.
  - NPC handshake at cycle N, then `imem_req_valid` with the new address at N+1.
- Minimum loop is 4 cycles per instruction with zero-wait memory and consumers.
- Arbitrary back-pressure on any port stalls the FSM in that state indefinitely with no loss of data.

## Configuration
- `IFU_MISALIGN_CHECK_EN` defined:
  - In REQ, if pc[1:0]!=0, no request is issued (`imem_req_valid`=0).
  - The FSM goes directly to OUT with `inst`=`NOP_INST` and `inst_fault`=1 on the next cycle.
- Not defined:
  - pc[1:0] is ignored; the fetch uses the aligned address and proceeds normally.

## Test plan
- Reset release, memory ready=1, rsp 1 cycle later with 32'h00500093: request addr 32'h80000000 at cycle 0; `inst`=32'h00500093, `inst_pc`=32'h80000000, `inst_valid`=1 at cycle 2.
- Back-pressure: `imem_req_ready`=0 for 3 cycles, then `inst_ready`=0 for 5 cycles: addr and `inst`/`inst_pc` held constant throughout; exactly one request and one delivery.
- Next PC: after delivery, drive `npc`=32'h80000010 with `npc_valid` 2 cycles late: `npc_ready` high for those cycles; next request addr 32'h80000010 one cycle after the handshake.
- Fault: response with `imem_rsp_err`=1 and data 32'hFFFFFFFF: `inst`=32'h00000013, `inst_fault`=1; the next clean fetch clears `inst_fault` to 0.
- Misalign, macro defined: `npc`=32'h80000006: no `imem_req_valid`; `inst_valid`=1 with `inst_fault`=1 and `inst_pc`=32'h80000006. Without the macro: request addr 32'h80000004.
- Reset in WAIT and in OUT: next cycle state is REQ, `inst_valid`=0, `imem_req_addr`=32'h80000000, `inst`=32'h00000013.
